// File: rtl/lsu_pkg.sv
// Shared types, width codes and access helpers for the load/store control unit.
// Misaligned-access splitting is controlled by the LSU_MISALIGN_EN macro in lsu_ctrl.
package lsu_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    typedef struct packed {
        lsu_state_t state;
        logic [1:0] cnt;
    } lsu_dbg_t;

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic mis;
        case (width)
            WIDTH_BYTE: mis = 1'b0;
            WIDTH_HALF: mis = addr_lo[0];
            default:    mis = |addr_lo;
        endcase
        return mis;
    endfunction

    // Index of the final memory access: 0 when aligned, else bytes-1.
    function automatic logic [1:0] last_index(input logic [1:0] width, input logic mis);
        logic [1:0] idx;
        if (!mis)                    idx = 2'd0;
        else if (width == WIDTH_HALF) idx = 2'd1;
        else                         idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [31:0] acc_wdata(input logic [31:0] wd, input logic mis,
                                              input logic [1:0] k);
        logic [31:0] res;
        if (!mis) res = wd;
        else      res = {24'h0, wd[{k, 3'b000} +: 8]};
        return res;
    endfunction

    function automatic logic [1:0] acc_width(input logic [1:0] width, input logic mis);
        return mis ? WIDTH_BYTE : width;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and data-memory port bundle of the load/store unit.
// Request: a transfer happens on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse with no ready.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_width;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_width, req_unsigned, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_addr, mem_wdata, mem_width
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_width, req_unsigned, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_addr, mem_wdata, mem_width
    );
endinterface

// File: rtl/lsu_ctrl_load_ext.sv
// Combinational sign/zero extender applied to assembled load data.
module load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  width_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);
    always_comb begin
        data_o = raw_i;
        case (width_i)
            WIDTH_BYTE: data_o = {{24{~unsigned_i & raw_i[7]}}, raw_i[7:0]};
            WIDTH_HALF: data_o = {{16{~unsigned_i & raw_i[15]}}, raw_i[15:0]};
            default:    data_o = raw_i;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control FSM: one request at a time, splits misaligned accesses into bytes.
// Build option LSU_MISALIGN_EN: split misaligned accesses; otherwise reject them with rsp_err.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    lsu_ctrl_if.slave  bus,
    output lsu_dbg_t   dbg_o
);
`ifdef LSU_MISALIGN_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_t  state_q;
    logic [1:0]  cnt_q;
    logic [1:0]  last_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  width_q;
    logic        uns_q;
    logic        mis_q;
    logic [31:0] asm_q;
    logic [31:0] asm_d;
    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic        mem_wr_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  mem_width_q;
    logic [1:0]  nxt_k;
    logic        mis_now;
    logic [31:0] ext_data;

    assign mis_now = is_misaligned(bus.req_width, bus.req_addr[1:0]);
    assign nxt_k   = cnt_q + 2'd1;

    // Split bytes land little-endian; an aligned access takes the whole bus.
    always_comb begin
        asm_d = asm_q;
        if (state_q == ACC) begin
            if (mis_q) asm_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
            else       asm_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            last_q      <= 2'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            width_q     <= WIDTH_BYTE;
            uns_q       <= 1'b0;
            mis_q       <= 1'b0;
            asm_q       <= 32'h0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_width_q <= WIDTH_BYTE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        width_q <= bus.req_width;
                        uns_q   <= bus.req_unsigned;
                        mis_q   <= mis_now;
                        last_q  <= last_index(bus.req_width, mis_now);
                        cnt_q   <= 2'd0;
                        asm_q   <= 32'h0;
                        ready_q <= 1'b0;
                        if (mis_now && !SPLIT_EN) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= ACC;
                            mem_wr_q    <= bus.req_we;
                            mem_addr_q  <= bus.req_addr;
                            mem_wdata_q <= acc_wdata(bus.req_wdata, mis_now, 2'd0);
                            mem_width_q <= acc_width(bus.req_width, mis_now);
                        end
                    end
                end
                ACC: begin
                    asm_q <= asm_d;
                    if (cnt_q == last_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        mem_wr_q    <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_wdata_q <= 32'h0;
                        mem_width_q <= WIDTH_BYTE;
                    end else begin
                        cnt_q       <= nxt_k;
                        mem_addr_q  <= addr_q + {30'h0, nxt_k};
                        mem_wdata_q <= acc_wdata(wdata_q, 1'b1, nxt_k);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    ready_q     <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    load_ext u_ext (
        .raw_i      (asm_q),
        .width_i    (width_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    assign bus.req_ready = ready_q & reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = (rsp_valid_q && !we_q && !rsp_err_q) ? ext_data : 32'h0;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_width = mem_width_q;
    assign dbg_o         = '{state: state_q, cnt: cnt_q};
endmodule
